branch_resolve_unit: RTL and testbench

//  Consumer/verifier end of the IF-stage BTB prediction path. Carries each fetched PC's prediction
//  (target, valid) through the ID and EX stages and compares it at EX with the actual outcome
//  (ID_EX_Branch, PCSrc, PC_Branch). On a mismatch it issues a registered redirect and a multi-cycle

---
 rtl/branch_resolve_unit_pkg.sv | 25 ++
 rtl/branch_resolve_unit_track.sv | 24 ++
 rtl/branch_resolve_unit.sv | 129 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve path: per-stage prediction record, flush FSM state, BTB index slice.
// No logic lives here; latency and backpressure are defined by the modules that import it.
package branch_resolve_unit_pkg;

  localparam int PC_width   = 32;
  localparam int BTB_IDX_HI = 9;
  localparam int BTB_IDX_LO = 2;

  typedef struct packed {
    logic                v;
    logic [PC_width-1:0] pc;
    logic [PC_width-1:0] pred_tgt;
    logic                pred_tk;
  } pred_rec_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic [BTB_IDX_HI-BTB_IDX_LO:0] btb_index(input logic [PC_width-1:0] pc);
    return pc[BTB_IDX_HI:BTB_IDX_LO];
  endfunction

endpackage

// File: rtl/branch_resolve_unit_track.sv
// One prediction tracking register: 1-cycle latency, holds on stall.
// A flush overrides the stall and clears the slot.
module pred_track_stage
  import branch_resolve_unit_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      stall,
  input  logic      flush,
  input  pred_rec_t d,
  output pred_rec_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Verifies IF-stage BTB predictions at EX; redirect/BTB update registered one cycle after resolve.
// Stall delays resolve until released; resolve is blocked while the multi-cycle flush is active.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_width    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_width-1:0]  IF_PC,
  input  logic [PC_width-1:0]  IF_Pred_Target,
  input  logic                 IF_Pred_Taken,
  input  logic                 IF_valid,
  input  logic                 Stall,
  input  logic                 ID_EX_Branch,
  input  logic                 PCSrc,
  input  logic [PC_width-1:0]  PC_Branch,
  output logic                 Redirect_valid,
  output logic [PC_width-1:0]  Redirect_PC,
  output logic                 Flush,
  output logic                 Upd_en,
  output logic [PC_width-1:0]  Upd_PC,
  output logic [PC_width-1:0]  Upd_Target,
  output logic                 Upd_Valid,
  output logic [CNT_width-1:0] Br_count,
  output logic [CNT_width-1:0] Mis_count
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  pred_rec_t if_rec, id_q, ex_q;
  state_t    state;
  logic [FCW-1:0] flush_cnt;

  logic                resolve, mispredict, taken;
  logic [PC_width-1:0] seq_pc, actual_next, pred_next;

  assign if_rec = '{v: IF_valid, pc: IF_PC, pred_tgt: IF_Pred_Target, pred_tk: IF_Pred_Taken};

  pred_track_stage u_id (
    .clk   (clk),
    .reset (reset),
    .stall (Stall),
    .flush (Flush),
    .d     (if_rec),
    .q     (id_q)
  );

  pred_track_stage u_ex (
    .clk   (clk),
    .reset (reset),
    .stall (Stall),
    .flush (Flush),
    .d     (id_q),
    .q     (ex_q)
  );

  // Sequential PC wraps naturally at the top of the address space.
  assign seq_pc      = ex_q.pc + PC_width'(4);
  assign taken       = ID_EX_Branch && PCSrc;
  assign actual_next = taken ? PC_Branch : seq_pc;
  assign pred_next   = ex_q.pred_tk ? ex_q.pred_tgt : seq_pc;
  assign resolve     = ex_q.v && !Stall && (state == IDLE);
  assign mispredict  = resolve && (actual_next != pred_next);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      Flush          <= 1'b0;
      Redirect_valid <= 1'b0;
      Redirect_PC    <= '0;
    end else begin
      Redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mispredict) begin
            state          <= FLUSH;
            flush_cnt      <= FCW'(FLUSH_CYCLES - 1);
            Flush          <= 1'b1;
            Redirect_valid <= 1'b1;
            Redirect_PC    <= actual_next;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state <= IDLE;
            Flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Flush <= 1'b0;
        end
      endcase
    end
  end

  // Taken branches always rewrite their entry; a predicted-taken non-branch drops an aliased entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Upd_en     <= 1'b0;
      Upd_PC     <= '0;
      Upd_Target <= '0;
      Upd_Valid  <= 1'b0;
      Br_count   <= '0;
      Mis_count  <= '0;
    end else begin
      Upd_en <= 1'b0;
      if (resolve && taken) begin
        Upd_en     <= 1'b1;
        Upd_PC     <= ex_q.pc;
        Upd_Target <= PC_Branch;
        Upd_Valid  <= 1'b1;
      end else if (resolve && !ID_EX_Branch && ex_q.pred_tk) begin
        Upd_en     <= 1'b1;
        Upd_PC     <= ex_q.pc;
        Upd_Target <= '0;
        Upd_Valid  <= 1'b0;
      end
      if (resolve && ID_EX_Branch && (Br_count != '1)) Br_count <= Br_count + 1'b1;
      if (mispredict && (Mis_count != '1)) Mis_count <= Mis_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; counters narrowed to 3 bits so saturation is reachable.
module tb_branch_resolve_unit;

  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_PC, IF_Pred_Target, PC_Branch;
  logic        IF_Pred_Taken, IF_valid, Stall, ID_EX_Branch, PCSrc;
  logic        Redirect_valid, Flush, Upd_en, Upd_Valid;
  logic [31:0] Redirect_PC, Upd_PC, Upd_Target;
  logic [CW-1:0] Br_count, Mis_count;

  int checks   = 0;
  int failures = 0;

  branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_width(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .IF_PC          (IF_PC),
    .IF_Pred_Target (IF_Pred_Target),
    .IF_Pred_Taken  (IF_Pred_Taken),
    .IF_valid       (IF_valid),
    .Stall          (Stall),
    .ID_EX_Branch   (ID_EX_Branch),
    .PCSrc          (PCSrc),
    .PC_Branch      (PC_Branch),
    .Redirect_valid (Redirect_valid),
    .Redirect_PC    (Redirect_PC),
    .Flush          (Flush),
    .Upd_en         (Upd_en),
    .Upd_PC         (Upd_PC),
    .Upd_Target     (Upd_Target),
    .Upd_Valid      (Upd_Valid),
    .Br_count       (Br_count),
    .Mis_count      (Mis_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one fetch, then let it advance into EX.
  task automatic fetch1(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    IF_valid = 1'b1; IF_PC = pc; IF_Pred_Target = tgt; IF_Pred_Taken = tk;
    cyc();
    IF_valid = 1'b0; IF_Pred_Taken = 1'b0;
    cyc();
  endtask

  task automatic resolve_ex(input logic br, input logic src, input logic [31:0] tgt);
    ID_EX_Branch = br; PCSrc = src; PC_Branch = tgt;
    cyc();
  endtask

  task automatic clear_ex();
    ID_EX_Branch = 1'b0; PCSrc = 1'b0; PC_Branch = '0;
  endtask

  initial begin
    reset = 1'b0; IF_PC = '0; IF_Pred_Target = '0; IF_Pred_Taken = 1'b0; IF_valid = 1'b0;
    Stall = 1'b0; ID_EX_Branch = 1'b0; PCSrc = 1'b0; PC_Branch = '0;
    #1;
    chk("rst_redirect", 32'(Redirect_valid), 0);
    chk("rst_flush",    32'(Flush), 0);
    chk("rst_upd_en",   32'(Upd_en), 0);
    chk("rst_rpc",      Redirect_PC, 0);
    chk("rst_br",       32'(Br_count), 0);
    chk("rst_mis",      32'(Mis_count), 0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // Cold miss: not predicted, taken to 0x80.
    fetch1(32'h40, 32'h0, 1'b0);
    resolve_ex(1'b1, 1'b1, 32'h80);
    chk("cold_redirect", 32'(Redirect_valid), 1);
    chk("cold_rpc",      Redirect_PC, 32'h80);
    chk("cold_upd_en",   32'(Upd_en), 1);
    chk("cold_upd_vld",  32'(Upd_Valid), 1);
    chk("cold_upd_pc",   Upd_PC, 32'h40);
    chk("cold_upd_tgt",  Upd_Target, 32'h80);
    chk("cold_flush0",   32'(Flush), 1);
    chk("cold_br",       32'(Br_count), 1);
    chk("cold_mis",      32'(Mis_count), 1);
    clear_ex();
    cyc();
    chk("cold_flush1",   32'(Flush), 1);
    chk("cold_redir_pulse", 32'(Redirect_valid), 0);
    chk("cold_upd_pulse",   32'(Upd_en), 0);
    cyc();
    chk("cold_flush2",   32'(Flush), 0);

    // Correct taken prediction.
    fetch1(32'h40, 32'h80, 1'b1);
    resolve_ex(1'b1, 1'b1, 32'h80);
    chk("ok_redirect", 32'(Redirect_valid), 0);
    chk("ok_flush",    32'(Flush), 0);
    chk("ok_upd_en",   32'(Upd_en), 1);
    chk("ok_upd_vld",  32'(Upd_Valid), 1);
    chk("ok_br",       32'(Br_count), 2);
    chk("ok_mis",      32'(Mis_count), 1);
    clear_ex();
    cyc();

    // Predicted taken, actually not taken.
    fetch1(32'h40, 32'h80, 1'b1);
    resolve_ex(1'b1, 1'b0, 32'h80);
    chk("wt_redirect", 32'(Redirect_valid), 1);
    chk("wt_rpc",      Redirect_PC, 32'h44);
    chk("wt_upd_en",   32'(Upd_en), 0);
    chk("wt_br",       32'(Br_count), 3);
    chk("wt_mis",      32'(Mis_count), 2);
    clear_ex();
    cyc(); cyc();
    chk("wt_flush_done", 32'(Flush), 0);

    // Alias: non-branch with a taken prediction.
    fetch1(32'h100, 32'h200, 1'b1);
    resolve_ex(1'b0, 1'b0, 32'h0);
    chk("al_redirect", 32'(Redirect_valid), 1);
    chk("al_rpc",      Redirect_PC, 32'h104);
    chk("al_upd_en",   32'(Upd_en), 1);
    chk("al_upd_vld",  32'(Upd_Valid), 0);
    chk("al_upd_pc",   Upd_PC, 32'h100);
    chk("al_br",       32'(Br_count), 3);
    chk("al_mis",      32'(Mis_count), 3);
    clear_ex();
    cyc(); cyc();

    // Stall with a branch in EX, followed by a would-be-mispredict in the shadow slot.
    IF_valid = 1'b1; IF_PC = 32'h40; IF_Pred_Target = '0; IF_Pred_Taken = 1'b0;
    cyc();
    IF_PC = 32'h44; IF_Pred_Target = 32'h300; IF_Pred_Taken = 1'b1;
    cyc();
    IF_valid = 1'b0; IF_Pred_Taken = 1'b0;
    Stall = 1'b1; ID_EX_Branch = 1'b1; PCSrc = 1'b1; PC_Branch = 32'h80;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("st_hold_redirect", 32'(Redirect_valid), 0);
      chk("st_hold_upd",      32'(Upd_en), 0);
    end
    Stall = 1'b0;
    cyc();
    chk("st_redirect", 32'(Redirect_valid), 1);
    chk("st_rpc",      Redirect_PC, 32'h80);
    chk("st_br",       32'(Br_count), 4);
    chk("st_mis",      32'(Mis_count), 4);
    clear_ex();
    cyc();
    chk("sh_redirect", 32'(Redirect_valid), 0);
    chk("sh_upd_en",   32'(Upd_en), 0);
    chk("sh_flush",    32'(Flush), 1);
    chk("sh_mis",      32'(Mis_count), 4);
    cyc();
    chk("sh_flush_done", 32'(Flush), 0);
    chk("sh_mis2",       32'(Mis_count), 4);

    // Reset asserted in the middle of a flush.
    fetch1(32'h40, 32'h0, 1'b0);
    resolve_ex(1'b1, 1'b1, 32'h80);
    chk("rf_flush_on", 32'(Flush), 1);
    clear_ex();
    #2 reset = 1'b0;
    #1;
    chk("rf_flush",    32'(Flush), 0);
    chk("rf_redirect", 32'(Redirect_valid), 0);
    chk("rf_upd_en",   32'(Upd_en), 0);
    chk("rf_br",       32'(Br_count), 0);
    chk("rf_mis",      32'(Mis_count), 0);
    reset = 1'b1;
    cyc();
    chk("rf_idle_flush", 32'(Flush), 0);

    // Top-of-memory wrap: sequential next PC is 0.
    fetch1(32'hFFFF_FFFC, 32'h0, 1'b0);
    resolve_ex(1'b1, 1'b0, 32'h1234);
    chk("wr_redirect", 32'(Redirect_valid), 0);
    chk("wr_upd_en",   32'(Upd_en), 0);
    chk("wr_br",       32'(Br_count), 1);
    chk("wr_mis",      32'(Mis_count), 0);
    clear_ex();
    cyc();
    fetch1(32'hFFFF_FFFC, 32'h0, 1'b1);
    resolve_ex(1'b1, 1'b0, 32'h1234);
    chk("wr2_redirect", 32'(Redirect_valid), 0);
    chk("wr2_flush",    32'(Flush), 0);
    chk("wr2_br",       32'(Br_count), 2);
    clear_ex();
    cyc();

    // Drive both counters past all-ones.
    for (int i = 0; i < 8; i++) begin
      fetch1(32'h40, 32'h0, 1'b0);
      resolve_ex(1'b1, 1'b1, 32'h80);
      clear_ex();
      cyc(); cyc();
    end
    chk("sat_br",  32'(Br_count), 7);
    chk("sat_mis", 32'(Mis_count), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
